// File: rtl/ntr_pkg.sv
// Shared types and constants for the cartridge command receiver.
// No logic of its own; zero latency.
// No flow control; constants only.
package ntr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } ntr_state_e;

    localparam logic [7:0] OP_DUMMY     = 8'h9F;
    localparam logic [7:0] OP_HEADER    = 8'h00;
    localparam logic [7:0] OP_CHIP_ID   = 8'h90;
    localparam logic [7:0] OP_DATA_READ = 8'hB7;

    localparam logic [2:0] CT_OTHER     = 3'd0;
    localparam logic [2:0] CT_DUMMY     = 3'd1;
    localparam logic [2:0] CT_HEADER    = 3'd2;
    localparam logic [2:0] CT_CHIP_ID   = 3'd3;
    localparam logic [2:0] CT_DATA_READ = 3'd4;

    function automatic logic [2:0] decode_op(input logic [7:0] op);
        logic [2:0] ct;
        ct = CT_OTHER;
        case (op)
            OP_DUMMY:     ct = CT_DUMMY;
            OP_HEADER:    ct = CT_HEADER;
            OP_CHIP_ID:   ct = CT_CHIP_ID;
            OP_DATA_READ: ct = CT_DATA_READ;
            default:      ct = CT_OTHER;
        endcase
        return ct;
    endfunction

endpackage

// File: rtl/up_counter.sv
// Free-running wrap-around up counter with synchronous clear (clear wins).
// Count visible one cycle after the enabling edge.
// No backpressure; counts every enabled cycle.
module up_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ntr_cmd_rx.sv
// Cartridge command receiver: 8-byte command capture, then response word requests.
// cmd_valid/word_req registered, one cycle after the sampling edge; cmd_type decode under NTR_CMD_DECODE_EN.
// No backpressure: the host clocks every cycle cs_n is low; excess response bytes raise resp_overrun.
module ntr_cmd_rx
    import ntr_pkg::*;
#(
    parameter int RESP_WORDS_MAX = 128
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cs_n,
    input  logic [7:0]                        bus_in,
    output logic [63:0]                       cmd,
    output logic                              cmd_valid,
    output logic                              resp_en,
    output logic                              word_req,
    output logic [$clog2(RESP_WORDS_MAX)-1:0] word_idx,
    output logic                              resp_overrun,
    output logic [2:0]                        cmd_type
);

    localparam int             IDXW     = $clog2(RESP_WORDS_MAX);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RESP_WORDS_MAX - 1);

    ntr_state_e      state_q, state_d;
    logic [63:0]     cmd_q, cmd_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            word_req_q, word_req_d;
    logic            resp_en_q, resp_en_d;
    logic [IDXW-1:0] word_idx_q, word_idx_d;
    logic            overrun_q, overrun_d;
    // Cleared by reset, set by any cs_n-high cycle: a transaction cut by reset is not resumed.
    logic            armed_q, armed_d;

    logic [1:0]      word_byte;
    logic            wb_clr;
    logic            wb_en;

    assign wb_clr = (state_q != RESP) || cs_n;
    assign wb_en  = (state_q == RESP) && !cs_n;

    up_counter #(
        .WIDTH (2)
    ) u_word_byte_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wb_clr),
        .en    (wb_en),
        .count (word_byte)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        byte_cnt_d  = byte_cnt_q;
        cmd_valid_d = 1'b0;
        word_req_d  = 1'b0;
        resp_en_d   = 1'b0;
        word_idx_d  = word_idx_q;
        overrun_d   = overrun_q;
        armed_d     = armed_q | cs_n;

        if (cs_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (armed_q) begin
                        cmd_d      = {56'h0, bus_in};
                        byte_cnt_d = 3'd1;
                        overrun_d  = 1'b0;
                        state_d    = CMD;
                    end
                end
                CMD: begin
                    cmd_d      = {cmd_q[55:0], bus_in};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        cmd_valid_d = 1'b1;
                        word_req_d  = 1'b1;
                        word_idx_d  = '0;
                        resp_en_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
                RESP: begin
                    resp_en_d = 1'b1;
                    if (word_byte == 2'd3) begin
                        // Last word already handed out: stop rather than wrap the index.
                        if (word_idx_q == IDX_LAST) begin
                            resp_en_d = 1'b0;
                            overrun_d = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            word_req_d = 1'b1;
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            byte_cnt_q  <= '0;
            cmd_valid_q <= 1'b0;
            word_req_q  <= 1'b0;
            resp_en_q   <= 1'b0;
            word_idx_q  <= '0;
            overrun_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            word_req_q  <= word_req_d;
            resp_en_q   <= resp_en_d;
            word_idx_q  <= word_idx_d;
            overrun_q   <= overrun_d;
            armed_q     <= armed_d;
        end
    end

`ifdef NTR_CMD_DECODE_EN
    logic [2:0] cmd_type_q, cmd_type_d;

    // The opcode byte sits at [55:48] on the edge that shifts in byte 7.
    always_comb begin
        cmd_type_d = cmd_type_q;
        if (cmd_valid_d) begin
            cmd_type_d = decode_op(cmd_q[55:48]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_type_q <= CT_OTHER;
        end else begin
            cmd_type_q <= cmd_type_d;
        end
    end

    assign cmd_type = cmd_type_q;
`else
    assign cmd_type = CT_OTHER;
`endif

    assign cmd          = cmd_q;
    assign cmd_valid    = cmd_valid_q;
    assign resp_en      = resp_en_q;
    assign word_req     = word_req_q;
    assign word_idx     = word_idx_q;
    assign resp_overrun = overrun_q;

endmodule

// File: tb/tb_ntr_cmd_rx.sv
// Bench for ntr_cmd_rx: default-depth and two-word instances share one host bus.
module tb_ntr_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic [7:0]  bus_in;

    logic [63:0] cmd_a, cmd_b;
    logic        cmd_valid_a, cmd_valid_b;
    logic        resp_en_a, resp_en_b;
    logic        word_req_a, word_req_b;
    logic [6:0]  word_idx_a;
    logic [0:0]  word_idx_b;
    logic        resp_overrun_a, resp_overrun_b;
    logic [2:0]  cmd_type_a, cmd_type_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ntr_cmd_rx u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_n         (cs_n),
        .bus_in       (bus_in),
        .cmd          (cmd_a),
        .cmd_valid    (cmd_valid_a),
        .resp_en      (resp_en_a),
        .word_req     (word_req_a),
        .word_idx     (word_idx_a),
        .resp_overrun (resp_overrun_a),
        .cmd_type     (cmd_type_a)
    );

    ntr_cmd_rx #(.RESP_WORDS_MAX(2)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_n         (cs_n),
        .bus_in       (bus_in),
        .cmd          (cmd_b),
        .cmd_valid    (cmd_valid_b),
        .resp_en      (resp_en_b),
        .word_req     (word_req_b),
        .word_idx     (word_idx_b),
        .resp_overrun (resp_overrun_b),
        .cmd_type     (cmd_type_b)
    );

    typedef struct {
        logic [63:0] bytes;
        int          n_cmd;
        int          n_resp;
        logic [2:0]  ctype;
        int          words_a;
        int          words_b;
        logic        ovr_b;
    } vec_t;

    typedef struct {
        logic [63:0] cmd;
        logic [2:0]  ct;
    } cexp_t;

    vec_t  vecs[6];
    cexp_t cmdq_a[$];
    cexp_t cmdq_b[$];
    int    idxq_a[$];
    int    idxq_b[$];

    function automatic logic [2:0] exp_ct(input logic [2:0] t);
`ifdef NTR_CMD_DECODE_EN
        return t;
`else
        return 3'd0 & t;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected pulse, expected none", name);
    endtask

    task automatic monitor();
        cexp_t e;
        int    w;
        if (cmd_valid_a) begin
            if (cmdq_a.size() == 0) unexpected("cmd_valid_a");
            else begin
                e = cmdq_a.pop_front();
                chk("cmd_a", cmd_a, e.cmd);
                chk("cmd_type_a", 64'(cmd_type_a), 64'(e.ct));
            end
        end
        if (cmd_valid_b) begin
            if (cmdq_b.size() == 0) unexpected("cmd_valid_b");
            else begin
                e = cmdq_b.pop_front();
                chk("cmd_b", cmd_b, e.cmd);
                chk("cmd_type_b", 64'(cmd_type_b), 64'(e.ct));
            end
        end
        if (word_req_a) begin
            if (idxq_a.size() == 0) unexpected("word_req_a");
            else begin
                w = idxq_a.pop_front();
                chk("word_idx_a", 64'(word_idx_a), 64'(w));
            end
        end
        if (word_req_b) begin
            if (idxq_b.size() == 0) unexpected("word_req_b");
            else begin
                w = idxq_b.pop_front();
                chk("word_idx_b", 64'(word_idx_b), 64'(w));
            end
        end
    endtask

    task automatic tick(input logic csn, input logic [7:0] b);
        cs_n   = csn;
        bus_in = b;
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [63:0] bb;
        cexp_t       e;
        v  = vecs[i];
        bb = v.bytes;
        if (v.n_cmd == 8) begin
            e.cmd = v.bytes;
            e.ct  = exp_ct(v.ctype);
            cmdq_a.push_back(e);
            cmdq_b.push_back(e);
        end
        for (int w = 0; w < v.words_a; w++) idxq_a.push_back(w);
        for (int w = 0; w < v.words_b; w++) idxq_b.push_back(w);

        for (int k = 0; k < v.n_cmd; k++) begin
            tick(1'b0, bb[63-8*k -: 8]);
            if (k == 0) chk("overrun_clear_b", 64'(resp_overrun_b), 64'd0);
            if (k < 7) chk("resp_en_cmd_a", 64'(resp_en_a), 64'd0);
        end
        if (v.n_cmd == 8) begin
            chk("cmd_valid_cycle9", 64'(cmd_valid_a), 64'd1);
            chk("word_req_cycle9", 64'(word_req_a), 64'd1);
            chk("resp_en_start_a", 64'(resp_en_a), 64'd1);
            chk("resp_en_start_b", 64'(resp_en_b), 64'd1);
        end
        for (int r = 1; r <= v.n_resp; r++) begin
            tick(1'b0, 8'($urandom_range(0, 255)));
            chk("resp_en_a", 64'(resp_en_a), 64'd1);
            chk("resp_en_b", 64'(resp_en_b), 64'(r < 8));
            chk("word_req_a_timing", 64'(word_req_a), 64'(r % 4 == 0));
            chk("word_req_b_timing", 64'(word_req_b), 64'(r == 4));
            chk("overrun_b_timing", 64'(resp_overrun_b), 64'(r >= 8));
        end
        tick(1'b1, 8'h00);
        chk("idle_resp_en_a", 64'(resp_en_a), 64'd0);
        chk("idle_resp_en_b", 64'(resp_en_b), 64'd0);
        chk("idle_overrun_a", 64'(resp_overrun_a), 64'd0);
        chk("idle_overrun_b", 64'(resp_overrun_b), 64'(v.ovr_b));
        if (v.n_cmd == 8) begin
            chk("cmd_hold_a", cmd_a, v.bytes);
            chk("word_idx_end_a", 64'(word_idx_a), 64'(v.words_a - 1));
            chk("word_idx_end_b", 64'(word_idx_b), 64'(v.words_b - 1));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_a"}, cmd_a, 64'd0);
        chk({tag, "_cmd_valid_a"}, 64'(cmd_valid_a), 64'd0);
        chk({tag, "_resp_en_a"}, 64'(resp_en_a), 64'd0);
        chk({tag, "_word_req_a"}, 64'(word_req_a), 64'd0);
        chk({tag, "_word_idx_a"}, 64'(word_idx_a), 64'd0);
        chk({tag, "_overrun_a"}, 64'(resp_overrun_a), 64'd0);
        chk({tag, "_cmd_type_a"}, 64'(cmd_type_a), 64'd0);
        chk({tag, "_resp_en_b"}, 64'(resp_en_b), 64'd0);
        chk({tag, "_overrun_b"}, 64'(resp_overrun_b), 64'd0);
    endtask

    initial begin
        //           bytes                  ncmd nresp type words_a words_b ovr_b
        vecs[0] = '{64'hB700001234000000, 8, 0,  3'd4, 1, 1, 1'b0};
        vecs[1] = '{64'h9F00000000000000, 8, 12, 3'd1, 4, 2, 1'b1};
        vecs[2] = '{64'h90A1B2C3D4000000, 5, 0,  3'd0, 0, 0, 1'b0};
        vecs[3] = '{64'h9000000000000000, 8, 4,  3'd3, 2, 2, 1'b0};
        vecs[4] = '{64'h0000000000000000, 8, 8,  3'd2, 3, 2, 1'b1};
        vecs[5] = '{64'h1122334455667788, 8, 3,  3'd0, 1, 1, 1'b0};

        rst_n  = 1'b0;
        cs_n   = 1'b1;
        bus_in = 8'h00;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(1'b1, 8'h00);

        // Back-to-back transactions separated by a single cs_n-high cycle.
        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset in the middle of a response with cs_n held low.
        begin
            cexp_t e;
            e.cmd = 64'h9F00000000000000;
            e.ct  = exp_ct(3'd1);
            cmdq_a.push_back(e);
            cmdq_b.push_back(e);
            idxq_a.push_back(0);
            idxq_b.push_back(0);
            for (int k = 0; k < 8; k++) tick(1'b0, (k == 0) ? 8'h9F : 8'h00);
            tick(1'b0, 8'h55);
            tick(1'b0, 8'h66);
            chk("pre_reset_resp_en_a", 64'(resp_en_a), 64'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk_all_zero("midreset");
            #2;
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick(1'b0, 8'hB7);
                chk("no_capture_cmd_a", cmd_a, 64'd0);
                chk("no_capture_resp_en_a", 64'(resp_en_a), 64'd0);
            end
            tick(1'b1, 8'h00);
            run_vec(0);
        end

        chk("left_cmd_a", 64'(cmdq_a.size()), 64'd0);
        chk("left_cmd_b", 64'(cmdq_b.size()), 64'd0);
        chk("left_idx_a", 64'(idxq_a.size()), 64'd0);
        chk("left_idx_b", 64'(idxq_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
